// File: rtl/reg_bus_arbiter.sv
// Shares one register port between NREQ requesters: round-robin arbitration,
// strobe sequencing, read capture. Define REG_ARB_FIXED_PRIO_EN for fixed priority.
module reg_bus_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_wr,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic [ADDR_W-1:0]        addr,
   output logic                     wr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     rd,
   input  logic [DATA_W-1:0]        rd_data,
   input  logic                     int_n,
   output logic                     irq
);

   // Handshake: a requester holds req_valid and its payload stable until the
   // cycle in which req_ready[i] is high; that cycle is the accept.
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state, state_d;
   logic [IDX_W-1:0]    owner, owner_d;
   logic                op_wr, op_wr_d;
   logic [2:0]          cnt, cnt_d;
   logic [ADDR_W-1:0]   addr_d;
   logic                wr_d, rd_d;
   logic [DATA_W-1:0]   wr_data_d, rsp_rdata_d;
   logic [NREQ-1:0]     rsp_valid_d;
   logic [IDX_W-1:0]    win;
   logic                any_req;

   function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

`ifdef REG_ARB_FIXED_PRIO_EN
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[IDX_W'(i)]) win = IDX_W'(i);
      end
   end
`else
   logic [IDX_W-1:0] ptr, ptr_d;
   logic             found;
   int               rr_idx;

   // Search begins one past the last grant so every requester gets a turn.
   always_comb begin
      win    = '0;
      found  = 1'b0;
      rr_idx = 0;
      for (int off = 1; off <= NREQ; off++) begin
         rr_idx = (int'(ptr) + off) % NREQ;
         if (!found && req_valid[IDX_W'(rr_idx)]) begin
            win   = IDX_W'(rr_idx);
            found = 1'b1;
         end
      end
   end
`endif

   assign any_req   = |req_valid;
   assign req_ready = (state == IDLE && any_req) ? onehot(win) : '0;

   always_comb begin
      state_d     = state;
      owner_d     = owner;
      op_wr_d     = op_wr;
      cnt_d       = cnt;
      addr_d      = addr;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      wr_data_d   = wr_data;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata;
`ifndef REG_ARB_FIXED_PRIO_EN
      ptr_d       = ptr;
`endif
      case (state)
         IDLE: begin
            if (any_req) begin
               state_d = ISSUE;
               owner_d = win;
               op_wr_d = req_wr[win];
               addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
`ifndef REG_ARB_FIXED_PRIO_EN
               ptr_d   = win;
`endif
               // Strobes are registered, so they are set up on the accept edge.
               if (req_wr[win]) begin
                  wr_d      = 1'b1;
                  wr_data_d = req_wdata[int'(win)*DATA_W +: DATA_W];
               end else begin
                  rd_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (op_wr) begin
               state_d     = RESP;
               rsp_valid_d = onehot(owner);
               rsp_rdata_d = '0;
            end else begin
               state_d = WAIT;
               cnt_d   = 3'(RD_LAT - 1);
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               state_d     = RESP;
               rsp_valid_d = onehot(owner);
               rsp_rdata_d = rd_data;
            end else begin
               cnt_d = cnt - 3'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         op_wr     <= 1'b0;
         cnt       <= '0;
         addr      <= '0;
         wr        <= 1'b0;
         rd        <= 1'b0;
         wr_data   <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
         ptr       <= IDX_W'(NREQ - 1);
`endif
      end else begin
         state     <= state_d;
         owner     <= owner_d;
         op_wr     <= op_wr_d;
         cnt       <= cnt_d;
         addr      <= addr_d;
         wr        <= wr_d;
         rd        <= rd_d;
         wr_data   <= wr_data_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
`ifndef REG_ARB_FIXED_PRIO_EN
         ptr       <= ptr_d;
`endif
      end
   end

   // Interrupt re-timing is independent of the transaction FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= ~int_n;
   end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter (NREQ=2, RD_LAT=3): write, read latency,
// grant order, back-pressure during WAIT, mid-transaction reset, irq re-timing.
module tb_reg_bus_arbiter;

   localparam int NREQ = 2, ADDR_W = 3, DATA_W = 8, RD_LAT = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid, req_wr, req_ready, rsp_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0]      rsp_rdata, wr_data, rd_data;
   logic [ADDR_W-1:0]      addr;
   logic                   wr, rd, int_n, irq;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] exp_q[$];

   reg_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .addr(addr), .wr(wr), .wr_data(wr_data), .rd(rd), .rd_data(rd_data),
      .int_n(int_n), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] w;
      logic [1:0] exp_rdy;
      logic       int_pat [5];
      logic       irq_exp [5];

      rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      rd_data = '0; int_n = 1'b1;
      next_cycle();
      next_cycle();
      check("rst_addr", 32'(addr), 0);
      check("rst_wr", 32'(wr), 0);
      check("rst_rd", 32'(rd), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      @(negedge clk); rst_n = 1'b1; #1;

      // Single write, requester 0
      @(negedge clk);
      req_valid = 2'b01; req_wr = 2'b01; req_addr = {3'd0, 3'h2}; req_wdata = {8'h00, 8'hA5};
      #1 check("wr_ready", 32'(req_ready), 32'h1);
      @(negedge clk); req_valid = '0; #1;
      check("wr_strobe", 32'(wr), 1);
      check("wr_rd_low", 32'(rd), 0);
      check("wr_addr", 32'(addr), 2);
      check("wr_data", 32'(wr_data), 32'hA5);
      check("wr_busy_ready", 32'(req_ready), 0);
      next_cycle();
      check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("wr_rsp_rdata", 32'(rsp_rdata), 0);
      check("wr_strobe_off", 32'(wr), 0);
      next_cycle();
      check("wr_rsp_done", 32'(rsp_valid), 0);

      // Read, requester 1, data appears at T+4
      @(negedge clk);
      req_valid = 2'b10; req_wr = 2'b00; req_addr = {3'h5, 3'd0};
      #1 check("rd_ready", 32'(req_ready), 32'h2);
      @(negedge clk); req_valid = '0; #1;
      check("rd_strobe", 32'(rd), 1);
      check("rd_wr_low", 32'(wr), 0);
      check("rd_addr", 32'(addr), 5);
      next_cycle();
      check("rd_strobe_once", 32'(rd), 0);
      check("rd_addr_hold", 32'(addr), 5);
      @(negedge clk); rd_data = 8'h11; #1;
      check("rd_no_early_rsp", 32'(rsp_valid), 0);
      @(negedge clk); rd_data = 8'h3C; #1;
      @(negedge clk); rd_data = 8'h00; #1;
      check("rd_rsp_valid", 32'(rsp_valid), 32'h2);
      check("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
      next_cycle();
      check("rd_rsp_done", 32'(rsp_valid), 0);

      // Both requesters continuously request writes
`ifdef REG_ARB_FIXED_PRIO_EN
      exp_q = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      @(negedge clk);
      req_valid = 2'b11; req_wr = 2'b11; req_addr = {3'h6, 3'h1}; req_wdata = {8'h61, 8'h10};
      #1;
      for (int t = 0; t < 4; t++) begin
         w = exp_q.pop_front();
         exp_rdy = (w == 2'd0) ? 2'b01 : 2'b10;
         check("arb_ready", 32'(req_ready), 32'(exp_rdy));
         next_cycle();
         check("arb_addr", 32'(addr), (w == 2'd0) ? 32'h1 : 32'h6);
         check("arb_wr_data", 32'(wr_data), (w == 2'd0) ? 32'h10 : 32'h61);
         next_cycle();
         check("arb_rsp_valid", 32'(rsp_valid), 32'(exp_rdy));
         @(negedge clk);
         if (t == 3) req_valid = '0;
         #1;
      end

      // Request from 1 arrives while a read by 0 is in WAIT
      req_valid = 2'b01; req_wr = 2'b00; req_addr = {3'h4, 3'h3}; req_wdata = {8'h77, 8'h00};
      #1 check("bp_ready0", 32'(req_ready), 32'h1);
      @(negedge clk); req_valid = 2'b00; #1;
      check("bp_rd_addr", 32'(addr), 3);
      @(negedge clk); req_valid = 2'b10; req_wr = 2'b10; #1;
      check("bp_wait1", 32'(req_ready), 0);
      next_cycle();
      check("bp_wait2", 32'(req_ready), 0);
      @(negedge clk); rd_data = 8'h5A; #1;
      check("bp_wait3", 32'(req_ready), 0);
      @(negedge clk); rd_data = 8'h00; #1;
      check("bp_resp_ready", 32'(req_ready), 0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'h5A);
      next_cycle();
      check("bp_accept", 32'(req_ready), 32'h2);
      @(negedge clk); req_valid = '0; #1;
      check("bp_wr", 32'(wr), 1);
      check("bp_wr_addr", 32'(addr), 4);
      next_cycle();
      check("bp_wr_rsp", 32'(rsp_valid), 32'h2);
      next_cycle();

      // Reset during WAIT of a read by requester 0
      req_valid = 2'b01; req_wr = 2'b00; req_addr = {3'h0, 3'h7};
      #1 check("rr_ready", 32'(req_ready), 32'h1);
      @(negedge clk); req_valid = '0; #1;
      @(negedge clk); rst_n = 1'b0; #1;
      @(negedge clk); rst_n = 1'b1; #1;
      check("rr_rsp_valid", 32'(rsp_valid), 0);
      check("rr_addr", 32'(addr), 0);
      check("rr_rd", 32'(rd), 0);
      check("rr_wr", 32'(wr), 0);
      check("rr_wr_data", 32'(wr_data), 0);
      check("rr_rsp_rdata", 32'(rsp_rdata), 0);
      for (int t = 0; t < 4; t++) begin
         next_cycle();
         check("rr_no_rsp", 32'(rsp_valid), 0);
      end
      @(negedge clk);
      req_valid = 2'b11; req_wr = 2'b11; req_addr = {3'h6, 3'h1};
      #1 check("rr_first_winner", 32'(req_ready), 32'h1);
      @(negedge clk); req_valid = '0; #1;
      next_cycle();
      next_cycle();

      // irq follows ~int_n one cycle late
      int_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      irq_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int t = 0; t < 5; t++) begin
         @(negedge clk); int_n = int_pat[t]; #1;
         check("irq", 32'(irq), 32'(irq_exp[t]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Strobes must never overlap.
   always @(negedge clk) begin
      if (rst_n) check("strobe_overlap", 32'(wr & rd), 0);
   end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Shares the 3-bit-address / 8-bit-data register port of the packet divider/reorder DUT between NREQ independent requesters, e.g. the host sequencer and the RX-packet service engine. Arbitrates one transaction at a time (round-robin by default), sequences the single-cycle wr/rd strobes and captures read data after a fixed latency. Returns a per-requester completion pulse and re-times the active-low int_n into an active-high irq. Sits between the requester logic and the register port pins.

## Interface
- NREQ, 2: number of requesters, 2..4
- ADDR_W, 3: register address width
- DATA_W, 8: register data width
- RD_LAT, 1: cycles from the rd strobe to valid rd_data at the port, 1..7
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  NREQ  requester i has a transaction pending
- req_wr  input  NREQ  1 = write, 0 = read
- req_addr  input  NREQ*ADDR_W  flat; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  input  NREQ*DATA_W  flat write data, same packing
- req_ready  output  NREQ  one-hot accept; combinational
- rsp_valid  output  NREQ  one-cycle completion pulse to the owner of the transaction
- rsp_rdata  output  DATA_W  read data, shared by all requesters, valid with rsp_valid
- addr  output  ADDR_W  register port address
- wr  output  1  register write strobe
- wr_data  output  DATA_W  register write data
- rd  output  1  register read strobe
- rd_data  input  DATA_W  register read data
- int_n  input  1  active-low RX-packet-available interrupt
- irq  output  1  registered ~int_n

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, select the winner and drive req_ready[winner]=1 in the same cycle.
  - Latch the winner's index, wr, addr and wdata.
  - Next state is ISSUE.
- ISSUE, exactly 1 cycle:
  - addr = latched address.
  - For a write: wr=1 and wr_data = latched data; next state is RESP.
  - For a read: rd=1; next state is WAIT.
- WAIT, exactly RD_LAT cycles:
  - A down-counter is loaded with RD_LAT-1.
  - rd_data is captured at the end of the last WAIT cycle.
  - addr holds its value throughout WAIT.
- RESP, 1 cycle:
  - rsp_valid[owner]=1.
  - rsp_rdata = captured data for a read, 8'h00 for a write.
  - Next state is IDLE.
- Arbitration: round-robin.
  - A last-grant pointer moves to the winner on each accept.
  - The search starts at pointer+1 modulo NREQ.
  - After reset the pointer is NREQ-1, so requester 0 wins first.
- Requester handshake:
  - req_valid, req_wr, req_addr and req_wdata must be held stable until req_ready.
  - Dropping req_valid before acceptance is legal; no transaction is issued.
- req_ready is 0 in every state except IDLE. A new request is never accepted while a transaction is outstanding.
- wr and rd are never high together. Each is high for at most one cycle per transaction.
- wr_data holds its last value when wr=0.
- irq = ~int_n, registered, with 1-cycle latency. It is independent of the FSM.

## Timing
- Reset values: state IDLE, addr 0, wr 0, wr_data 0, rd 0, rsp_valid 0, rsp_rdata 0, irq 0, req_ready 0.
- Reset asserted mid-transaction:
  - The transaction is abandoned with no rsp_valid.
  - Strobes are low in the cycle after the reset edge.
- Write: accept at cycle T, wr at T+1, rsp_valid at T+2, next accept possible at T+3. One write per 3 cycles.
- Read: accept at T, rd at T+1, rd_data sampled at the end of T+1+RD_LAT, rsp_valid at T+2+RD_LAT, next accept possible at T+3+RD_LAT.
- A request that arrives during RESP is accepted in the following IDLE cycle. No cycle is skipped beyond IDLE.
- All outputs except req_ready come from flops.

## Configuration
- REG_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. The pointer logic is removed.
  - Undefined (default): round-robin as above.

## Test plan
- Single write, requester 0, addr 3'h2, data 8'hA5:
  - req_ready[0] in cycle T.
  - wr=1, addr=2, wr_data=A5 in T+1.
  - rsp_valid=2'b01, rsp_rdata=00 in T+2.
- Read with RD_LAT=3, requester 1, addr 3'h5; the port returns 8'h3C at T+4:
  - rd=1 in T+1 only.
  - rsp_valid=2'b10, rsp_rdata=3C in T+5.
- Both requesters hold req_valid for 4 transactions:
  - Grant order 0,1,0,1.
  - With REG_ARB_FIXED_PRIO_EN, order 0,0,0,0 while req_valid[0] stays high.
- Request arriving while a read is in WAIT: req_ready stays 0 until the IDLE after RESP, then the request is accepted.
- rst_n=0 in the WAIT cycle of a read: no rsp_valid, all outputs at reset values next cycle, and requester 0 wins the next arbitration.
- int_n 1→0→1 (low for 2 cycles): irq high for the same 2 cycles, delayed by 1.
